rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_wport_arb.sv | 94 +++++++++
 tb/tb_rf_wport_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: round-robin between ALU and load-unit writebacks,
// one-cycle registered commit, and a per-register write-pending scoreboard.
// Define RF_ARB_WCNT_EN to build the rf_cwe commit-count strobe; otherwise it is tied low.
module rf_wport_arb #(
   parameter int DW = 16,
   parameter int AW = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic                 a_valid,
   input  logic [AW-1:0]        a_wad,
   input  logic [DW-1:0]        a_wd,
   output logic                 a_ready,
   input  logic                 m_valid,
   input  logic [AW-1:0]        m_wad,
   input  logic [DW-1:0]        m_wd,
   output logic                 m_ready,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   output logic                 iss_ready,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_wad,
   output logic [DW-1:0]        rf_wd,
   output logic                 rf_cwe,
   output logic [(2**AW)-1:0]   busy
);

   localparam int NREG = 2**AW;

   // 1 when the load unit won the most recent transfer; reset value favours m on the first tie
   logic            last_m_reg;
   logic            rf_we_reg;
   logic [AW-1:0]   rf_wad_reg;
   logic [DW-1:0]   rf_wd_reg;
   logic [NREG-1:0] busy_reg;
   logic [NREG-1:0] busy_next;
   logic            xfer;

   assign a_ready   = !rst && !hold && a_valid && (!m_valid || last_m_reg);
   assign m_ready   = !rst && !hold && m_valid && (!a_valid || !last_m_reg);
   assign xfer      = a_ready || m_ready;
   assign iss_ready = !rst && iss_valid && !busy_reg[iss_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_m_reg <= 1'b0;
         rf_we_reg  <= 1'b0;
         rf_wad_reg <= '0;
         rf_wd_reg  <= '0;
      end else begin
         rf_we_reg <= xfer;
         if (xfer) begin
            last_m_reg <= m_ready;
            rf_wad_reg <= m_ready ? m_wad : a_wad;
            rf_wd_reg  <= m_ready ? m_wd  : a_wd;
         end
      end
   end

   // A reservation landing on the same edge as the commit clear keeps the bit set
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_busy
         logic set_w;
         logic clr_w;
         assign set_w         = iss_ready && (iss_rd == AW'(gi));
         assign clr_w         = rf_we_reg && (rf_wad_reg == AW'(gi));
         assign busy_next[gi] = set_w || (busy_reg[gi] && !clr_w);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_reg <= '0;
      else     busy_reg <= busy_next;
   end

`ifdef RF_ARB_WCNT_EN
   logic rf_cwe_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rf_cwe_reg <= 1'b0;
      else     rf_cwe_reg <= xfer;
   end
   assign rf_cwe = rf_cwe_reg;
`else
   assign rf_cwe = 1'b0;
`endif

   assign rf_we  = rf_we_reg;
   assign rf_wad = rf_wad_reg;
   assign rf_wd  = rf_wd_reg;
   assign busy   = busy_reg;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed and randomized checks of rf_wport_arb against a transaction-level reference model.
module tb_rf_wport_arb;
   localparam int DW = 16;
   localparam int AW = 2;
   localparam int NREG = 4;

   logic clk = 1'b0;
   logic rst, hold;
   logic a_valid, m_valid, iss_valid;
   logic [AW-1:0] a_wad, m_wad, iss_rd;
   logic [DW-1:0] a_wd, m_wd;
   logic a_ready, m_ready, iss_ready;
   logic rf_we, rf_cwe;
   logic [AW-1:0] rf_wad;
   logic [DW-1:0] rf_wd;
   logic [NREG-1:0] busy;

   int tests = 0;
   int fails = 0;

   // Reference model: who won last, what commit is pending, which registers are reserved
   bit        mdl_last_m;
   bit        mdl_we;
   int        mdl_wad;
   int        mdl_wd;
   bit        mdl_busy [NREG];
   int        cwe_pulses;

   rf_wport_arb #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .a_valid(a_valid), .a_wad(a_wad), .a_wd(a_wd), .a_ready(a_ready),
      .m_valid(m_valid), .m_wad(m_wad), .m_wd(m_wd), .m_ready(m_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rf_we(rf_we), .rf_wad(rf_wad), .rf_wd(rf_wd), .rf_cwe(rf_cwe), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_last_m = 1'b0;
      mdl_we     = 1'b0;
      mdl_wad    = 0;
      mdl_wd     = 0;
      foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
   endtask

   function automatic logic [31:0] busy_vec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) v[i] = mdl_busy[i];
      return v;
   endfunction

   // One clock of stimulus: drive after the falling edge, check, then advance the model at the rising edge
   task automatic step(input bit av, input int awad, input int awd,
                       input bit mv, input int mwad, input int mwd,
                       input bit hd, input bit iv, input int ird);
      bit ga, gm, gis;
      @(negedge clk);
      a_valid = av;  a_wad = AW'(awad); a_wd = DW'(awd);
      m_valid = mv;  m_wad = AW'(mwad); m_wd = DW'(mwd);
      hold = hd;     iss_valid = iv;    iss_rd = AW'(ird);
      #1;
      // Single requester wins outright; on a tie the one not granted last time wins
      ga  = av && !hd && (!mv || mdl_last_m);
      gm  = mv && !hd && (!av || !mdl_last_m);
      gis = iv && !mdl_busy[ird];
      chk("a_ready", 32'(a_ready), 32'(ga));
      chk("m_ready", 32'(m_ready), 32'(gm));
      chk("iss_ready", 32'(iss_ready), 32'(gis));
      chk("rf_we", 32'(rf_we), 32'(mdl_we));
      chk("rf_wad", 32'(rf_wad), mdl_wad);
      chk("rf_wd", 32'(rf_wd), mdl_wd);
`ifdef RF_ARB_WCNT_EN
      chk("rf_cwe", 32'(rf_cwe), 32'(mdl_we));
`else
      chk("rf_cwe", 32'(rf_cwe), 32'd0);
`endif
      chk("busy", 32'(busy), busy_vec());
      if (rf_cwe) cwe_pulses++;
      @(posedge clk);
      if (mdl_we) mdl_busy[mdl_wad] = 1'b0;
      if (gis)    mdl_busy[ird] = 1'b1;
      mdl_we = ga || gm;
      if (ga) begin mdl_wad = awad; mdl_wd = awd; end
      if (gm) begin mdl_wad = mwad; mdl_wd = mwd; end
      if (ga || gm) mdl_last_m = gm;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0;
      a_valid = 1'b1; a_wad = '0; a_wd = '0;
      m_valid = 1'b1; m_wad = '0; m_wd = '0;
      iss_valid = 1'b1; iss_rd = '0;
      cwe_pulses = 0;
      model_reset();
      #12;
      chk("rst a_ready", 32'(a_ready), 32'd0);
      chk("rst m_ready", 32'(m_ready), 32'd0);
      chk("rst iss_ready", 32'(iss_ready), 32'd0);
      chk("rst rf_we", 32'(rf_we), 32'd0);
      chk("rst rf_wad", 32'(rf_wad), 32'd0);
      chk("rst rf_wd", 32'(rf_wd), 32'd0);
      chk("rst rf_cwe", 32'(rf_cwe), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0; a_valid = 1'b0; m_valid = 1'b0; iss_valid = 1'b0;

      // Single ALU write, then the commit cycle, then idle
      step(1, 2, 'h1234, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("single rf_wad", 32'(rf_wad), 32'd2);
      chk("single rf_wd", 32'(rf_wd), 32'h1234);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Continuous contention alternates m, a, m, a
      for (int i = 0; i < 4; i++) step(1, 1, 'h100 + i, 1, 3, 'h300 + i, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Scoreboard: reserve r1, blocked repeat, commit clears it
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("waw busy", 32'(busy), 32'b0010);
      step(1, 1, 'hbeef, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("cleared busy", 32'(busy), 32'd0);

      // Reservation on the commit cycle of the same register wins
      step(1, 0, 'h5a5a, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("set wins", 32'(busy[0]), 32'd1);

      // Hold suppresses grants; release resumes with whoever is due
      for (int i = 0; i < 3; i++) step(1, 2, 'h11, 1, 1, 'h22, 1, 0, 0);
      for (int i = 0; i < 2; i++) step(1, 2, 'h11, 1, 1, 'h22, 0, 0, 0);

      // Asynchronous reset during a commit cycle drops it immediately
      step(1, 3, 'h7777, 0, 0, 0, 0, 0, 0);
      a_valid = 1'b0;
      #2; rst = 1'b1; #1;
      chk("midrst rf_we", 32'(rf_we), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      cwe_pulses = 0;
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom_range(0, 'hffff),
              $urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom_range(0, 'hffff),
              ($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, NREG - 1));
`ifndef RF_ARB_WCNT_EN
      chk("cwe pulses", 32'(cwe_pulses), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
